// File: rtl/tile_pipe_pkg.sv
// Shared types and sizing helpers for the double-buffered tile pipeline controller.
package tile_pipe_pkg;

    typedef enum logic [1:0] {
        BUF_FREE,
        BUF_LOADED,
        BUF_COMPUTED
    } buf_state_t;

    typedef enum logic {
        STG_IDLE,
        STG_RUN
    } stage_state_t;

    localparam int unsigned DEF_IMG_W  = 64;
    localparam int unsigned DEF_IMG_H  = 64;
    localparam int unsigned DEF_TILE_W = 16;
    localparam int unsigned DEF_TILE_H = 16;

    // Number of tiles along one axis.
    function automatic int unsigned tile_count(input int unsigned img, input int unsigned tile);
        return img / tile;
    endfunction

    // Coordinate width for n tiles, never narrower than one bit.
    function automatic int unsigned coord_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_pipe_overlap_ctrl_stage.sv
// One pipeline stage sequencer: IDLE/RUN handshake FSM, raster tile counter and
// registered job descriptor (start pulse, tile coordinates, buffer slot).
module tile_stage_seq
    import tile_pipe_pkg::*;
#(
    parameter int unsigned TX = 4,
    parameter int unsigned TY = 4,
    parameter int unsigned XW = 2,
    parameter int unsigned YW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,      // frame start accepted: re-arm after a finished frame
    input  logic          enable,     // busy and the slot of the next tile is ready
    input  logic          done,
    output logic          launched,   // 1-cycle start pulse
    output logic          completed,  // done accepted this cycle
    output logic          err,        // done seen while idle
    output logic          slot,       // slot of the next tile to launch
    output logic [XW-1:0] tile_x,
    output logic [YW-1:0] tile_y,
    output logic          job_buf
);

    localparam logic [XW-1:0] XLAST = XW'(TX - 1);
    localparam logic [YW-1:0] YLAST = YW'(TY - 1);

    stage_state_t  state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          slot_q, slot_d;
    logic          fin_q, fin_d;   // all tiles of the frame done
    logic          launch;
    logic          is_last;

    assign is_last = (x_q == XLAST) && (y_q == YLAST);
    assign slot    = slot_q;

    // Next state: launch from IDLE, retire on done and advance the raster counter
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        slot_d    = slot_q;
        fin_d     = fin_q;
        launch    = 1'b0;
        completed = 1'b0;
        err       = 1'b0;
        if (clear) begin
            fin_d = 1'b0;
        end
        unique case (state_q)
            STG_IDLE: begin
                err = done;
                if (enable && (!fin_q || clear)) begin
                    launch  = 1'b1;
                    state_d = STG_RUN;
                end
            end
            STG_RUN: begin
                if (done) begin
                    completed = 1'b1;
                    state_d   = STG_IDLE;
                    if (is_last) begin
                        x_d    = '0;
                        y_d    = '0;
                        slot_d = 1'b0;
                        fin_d  = 1'b1;
                    end else begin
                        // Slot follows the linear tile index LSB
                        slot_d = ~slot_q;
                        if (x_q == XLAST) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end
            end
            default: state_d = STG_IDLE;
        endcase
    end

    // State, counter and job descriptor registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= STG_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            slot_q   <= 1'b0;
            fin_q    <= 1'b0;
            launched <= 1'b0;
            tile_x   <= '0;
            tile_y   <= '0;
            job_buf  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            slot_q   <= slot_d;
            fin_q    <= fin_d;
            launched <= launch;
            if (launch) begin
                tile_x  <= x_q;
                tile_y  <= y_q;
                job_buf <= slot_q;
            end
        end
    end

endmodule

// File: rtl/tile_pipe_overlap_ctrl.sv
// Double-buffered tile pipeline controller: overlaps the fetch of tile N+1 with the
// compute/store of tile N, using two buffer slots selected by the tile index LSB.
module tile_pipe_overlap_ctrl
    import tile_pipe_pkg::*;
#(
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned IMG_H  = DEF_IMG_H,
    parameter int unsigned TILE_W = DEF_TILE_W,
    parameter int unsigned TILE_H = DEF_TILE_H,
    localparam int unsigned TX = tile_count(IMG_W, TILE_W),
    localparam int unsigned TY = tile_count(IMG_H, TILE_H),
    localparam int unsigned XW = coord_width(TX),
    localparam int unsigned YW = coord_width(TY)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          frame_done,
    output logic          proto_err,
    output logic          dma_start,
    input  logic          dma_done,
    output logic [XW-1:0] dma_tile_x,
    output logic [YW-1:0] dma_tile_y,
    output logic          dma_buf,
    output logic          cmp_start,
    input  logic          cmp_done,
    output logic [XW-1:0] cmp_tile_x,
    output logic [YW-1:0] cmp_tile_y,
    output logic          cmp_buf,
    output logic          st_start,
    input  logic          st_done,
    output logic [XW-1:0] st_tile_x,
    output logic [YW-1:0] st_tile_y,
    output logic          st_buf
);

    if (IMG_W % TILE_W != 0) begin : g_bad_w
        $error("IMG_W must be a multiple of TILE_W");
    end
    if (IMG_H % TILE_H != 0) begin : g_bad_h
        $error("IMG_H must be a multiple of TILE_H");
    end

    localparam logic [XW-1:0] XLAST = XW'(TX - 1);
    localparam logic [YW-1:0] YLAST = YW'(TY - 1);

    buf_state_t slot_q [2];
    buf_state_t slot_d [2];

    logic start_acc, active, frame_end;
    logic dma_en, cmp_en, st_en;
    logic dma_cpl, cmp_cpl, st_cpl;
    logic dma_err, cmp_err, st_err;
    logic dma_slot, cmp_slot, st_slot;
    logic busy_d, proto_err_d;

    assign start_acc = start && !busy;
    // A start accepted this cycle lets the DMA launch on the same edge that raises busy
    assign active    = busy || start_acc;
    assign dma_en    = active && (slot_q[dma_slot] == BUF_FREE);
    assign cmp_en    = active && (slot_q[cmp_slot] == BUF_LOADED);
    assign st_en     = active && (slot_q[st_slot] == BUF_COMPUTED);
    assign frame_end = st_cpl && (st_tile_x == XLAST) && (st_tile_y == YLAST);

    tile_stage_seq #(.TX(TX), .TY(TY), .XW(XW), .YW(YW)) u_dma (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_acc),
        .enable    (dma_en),
        .done      (dma_done),
        .launched  (dma_start),
        .completed (dma_cpl),
        .err       (dma_err),
        .slot      (dma_slot),
        .tile_x    (dma_tile_x),
        .tile_y    (dma_tile_y),
        .job_buf   (dma_buf)
    );

    tile_stage_seq #(.TX(TX), .TY(TY), .XW(XW), .YW(YW)) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_acc),
        .enable    (cmp_en),
        .done      (cmp_done),
        .launched  (cmp_start),
        .completed (cmp_cpl),
        .err       (cmp_err),
        .slot      (cmp_slot),
        .tile_x    (cmp_tile_x),
        .tile_y    (cmp_tile_y),
        .job_buf   (cmp_buf)
    );

    tile_stage_seq #(.TX(TX), .TY(TY), .XW(XW), .YW(YW)) u_st (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_acc),
        .enable    (st_en),
        .done      (st_done),
        .launched  (st_start),
        .completed (st_cpl),
        .err       (st_err),
        .slot      (st_slot),
        .tile_x    (st_tile_x),
        .tile_y    (st_tile_y),
        .job_buf   (st_buf)
    );

    // Slot lifecycle and frame-level status next state
    always_comb begin
        slot_d      = slot_q;
        busy_d      = busy;
        proto_err_d = proto_err;
        // Concurrent completions always target distinct slots
        if (dma_cpl) slot_d[dma_buf] = BUF_LOADED;
        if (cmp_cpl) slot_d[cmp_buf] = BUF_COMPUTED;
        if (st_cpl)  slot_d[st_buf]  = BUF_FREE;
        if (frame_end) begin
            busy_d = 1'b0;
        end else if (start_acc) begin
            busy_d = 1'b1;
        end
        if (start_acc) proto_err_d = 1'b0;
        if (dma_err || cmp_err || st_err) proto_err_d = 1'b1;
    end

    // Slot and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q[0]  <= BUF_FREE;
            slot_q[1]  <= BUF_FREE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            slot_q[0]  <= slot_d[0];
            slot_q[1]  <= slot_d[1];
            busy       <= busy_d;
            frame_done <= frame_end;
            proto_err  <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_tile_pipe_overlap_ctrl.sv
// Bench for tile_pipe_overlap_ctrl: latency-programmable engine responders, a per-engine
// scoreboard of expected jobs in raster order, and scenario tasks with inline checks.
module tb_tile_pipe_overlap_ctrl;

    localparam int NT = 16;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
        logic       b;
    } job_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, frame_done, proto_err;
    logic dma_start, cmp_start, st_start;
    logic dma_done = 1'b0, cmp_done = 1'b0, st_done = 1'b0;
    logic [1:0] dma_tile_x, dma_tile_y, cmp_tile_x, cmp_tile_y, st_tile_x, st_tile_y;
    logic dma_buf, cmp_buf, st_buf;

    logic s_start = 1'b0;
    logic s_busy, s_frame_done, s_proto_err;
    logic s_dma_start, s_cmp_start, s_st_start;
    logic s_dma_done = 1'b0, s_cmp_done = 1'b0, s_st_done = 1'b0;
    logic s_dma_x, s_dma_y, s_dma_buf, s_cmp_x, s_cmp_y, s_cmp_buf, s_st_x, s_st_y, s_st_buf;

    int vec = 0;
    int errs = 0;
    int cyc = 0;
    bit auto_resp = 1'b0;
    int dma_lat = 4, cmp_lat = 4, st_lat = 1;

    job_t q_dma[$], q_cmp[$], q_st[$];
    int n_dma, n_cmp, n_st, n_dd, n_cd, n_std, n_fd, fd_cyc, t_start;
    int dma_start_cyc [NT];
    int cmp_start_cyc [NT];
    int dma_done_cyc  [NT];
    int st_done_cyc   [NT];

    tile_pipe_overlap_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .proto_err  (proto_err),
        .dma_start  (dma_start),
        .dma_done   (dma_done),
        .dma_tile_x (dma_tile_x),
        .dma_tile_y (dma_tile_y),
        .dma_buf    (dma_buf),
        .cmp_start  (cmp_start),
        .cmp_done   (cmp_done),
        .cmp_tile_x (cmp_tile_x),
        .cmp_tile_y (cmp_tile_y),
        .cmp_buf    (cmp_buf),
        .st_start   (st_start),
        .st_done    (st_done),
        .st_tile_x  (st_tile_x),
        .st_tile_y  (st_tile_y),
        .st_buf     (st_buf)
    );

    tile_pipe_overlap_ctrl #(.IMG_W(16), .IMG_H(16), .TILE_W(16), .TILE_H(16)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (s_start),
        .busy       (s_busy),
        .frame_done (s_frame_done),
        .proto_err  (s_proto_err),
        .dma_start  (s_dma_start),
        .dma_done   (s_dma_done),
        .dma_tile_x (s_dma_x),
        .dma_tile_y (s_dma_y),
        .dma_buf    (s_dma_buf),
        .cmp_start  (s_cmp_start),
        .cmp_done   (s_cmp_done),
        .cmp_tile_x (s_cmp_x),
        .cmp_tile_y (s_cmp_y),
        .cmp_buf    (s_cmp_buf),
        .st_start   (s_st_start),
        .st_done    (s_st_done),
        .st_tile_x  (s_st_x),
        .st_tile_y  (s_st_y),
        .st_buf     (s_st_buf)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Responders act at the falling edge; the monitor samples 1 ns later, tasks 2 ns later.
    initial begin : dma_resp
        int cnt;
        cnt = -1;
        forever begin
            @(negedge clk);
            if (rst) cnt = -1;
            if (auto_resp) begin
                dma_done = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        dma_done = 1'b1;
                        cnt = -1;
                        if (n_dd < NT) dma_done_cyc[n_dd] = cyc;
                        n_dd++;
                    end
                end
                if (!rst && dma_start) cnt = dma_lat;
            end
        end
    end

    initial begin : cmp_resp
        int cnt;
        cnt = -1;
        forever begin
            @(negedge clk);
            if (rst) cnt = -1;
            if (auto_resp) begin
                cmp_done = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        cmp_done = 1'b1;
                        cnt = -1;
                        n_cd++;
                    end
                end
                if (!rst && cmp_start) cnt = cmp_lat;
            end
        end
    end

    initial begin : st_resp
        int cnt;
        cnt = -1;
        forever begin
            @(negedge clk);
            if (rst) cnt = -1;
            if (auto_resp) begin
                st_done = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        st_done = 1'b1;
                        cnt = -1;
                        if (n_std < NT) st_done_cyc[n_std] = cyc;
                        n_std++;
                    end
                end
                if (!rst && st_start) cnt = st_lat;
            end
        end
    end

    // Scoreboard: pop the expected job on every start pulse
    initial begin : monitor
        job_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (dma_start) begin
                    vec++;
                    if (q_dma.size() == 0) begin
                        errs++;
                        $display("FAIL dma_order: extra start x=%0d y=%0d buf=%0d, none expected",
                                 dma_tile_x, dma_tile_y, dma_buf);
                    end else begin
                        e = q_dma.pop_front();
                        if ({dma_tile_x, dma_tile_y, dma_buf} !== e) begin
                            errs++;
                            $display("FAIL dma_order: got x=%0d y=%0d buf=%0d, expected x=%0d y=%0d buf=%0d",
                                     dma_tile_x, dma_tile_y, dma_buf, e.x, e.y, e.b);
                        end
                    end
                    vec++;
                    if (n_dma - n_std >= 2) begin
                        errs++;
                        $display("FAIL dma_inflight: %0d tiles outstanding at start, expected at most 1",
                                 n_dma - n_std);
                    end
                    if (n_dma < NT) dma_start_cyc[n_dma] = cyc;
                    n_dma++;
                end
                if (cmp_start) begin
                    vec++;
                    if (q_cmp.size() == 0) begin
                        errs++;
                        $display("FAIL cmp_order: extra start x=%0d y=%0d buf=%0d, none expected",
                                 cmp_tile_x, cmp_tile_y, cmp_buf);
                    end else begin
                        e = q_cmp.pop_front();
                        if ({cmp_tile_x, cmp_tile_y, cmp_buf} !== e) begin
                            errs++;
                            $display("FAIL cmp_order: got x=%0d y=%0d buf=%0d, expected x=%0d y=%0d buf=%0d",
                                     cmp_tile_x, cmp_tile_y, cmp_buf, e.x, e.y, e.b);
                        end
                    end
                    if (n_cmp < NT) cmp_start_cyc[n_cmp] = cyc;
                    n_cmp++;
                end
                if (st_start) begin
                    vec++;
                    if (q_st.size() == 0) begin
                        errs++;
                        $display("FAIL st_order: extra start x=%0d y=%0d buf=%0d, none expected",
                                 st_tile_x, st_tile_y, st_buf);
                    end else begin
                        e = q_st.pop_front();
                        if ({st_tile_x, st_tile_y, st_buf} !== e) begin
                            errs++;
                            $display("FAIL st_order: got x=%0d y=%0d buf=%0d, expected x=%0d y=%0d buf=%0d",
                                     st_tile_x, st_tile_y, st_buf, e.x, e.y, e.b);
                        end
                    end
                    n_st++;
                end
                if (frame_done) begin
                    fd_cyc = cyc;
                    n_fd++;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    function automatic int get_cnt(input int which);
        case (which)
            0:       return n_dma;
            1:       return n_cmp;
            2:       return n_st;
            3:       return n_std;
            default: return n_fd;
        endcase
    endfunction

    task automatic wait_count(input int which, input int target, input int limit, output bit ok);
        ok = (get_cnt(which) >= target);
        for (int n = 0; n < limit && !ok; n++) begin
            step();
            ok = (get_cnt(which) >= target);
        end
    endtask

    task automatic arm_frame();
        job_t j;
        q_dma.delete();
        q_cmp.delete();
        q_st.delete();
        n_dma = 0; n_cmp = 0; n_st = 0; n_dd = 0; n_cd = 0; n_std = 0; n_fd = 0;
        fd_cyc = -1;
        for (int i = 0; i < NT; i++) begin
            j.x = 2'(i % 4);
            j.y = 2'(i / 4);
            j.b = 1'(i % 2);
            q_dma.push_back(j);
            q_cmp.push_back(j);
            q_st.push_back(j);
        end
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        t_start = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        start = 1'b0;
        if (!auto_resp) begin
            dma_done = 1'b0;
            cmp_done = 1'b0;
            st_done = 1'b0;
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_frame_counts(input string tag);
        vec++;
        if (n_dma != NT || n_cmp != NT || n_st != NT || q_dma.size() + q_cmp.size() + q_st.size() != 0) begin
            errs++;
            $display("FAIL %s_counts: starts dma=%0d cmp=%0d st=%0d, expected %0d each", tag, n_dma, n_cmp,
                     n_st, NT);
        end
    endtask

    task automatic test_reset();
        logic [20:0] outs;
        auto_resp = 1'b0;
        do_reset();
        outs = {busy, frame_done, proto_err, dma_start, dma_tile_x, dma_tile_y, dma_buf, cmp_start,
                cmp_tile_x, cmp_tile_y, cmp_buf, st_start, st_tile_x, st_tile_y, st_buf};
        vec++;
        if (outs !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
        step();
        step();
        outs = {busy, frame_done, proto_err, dma_start, dma_tile_x, dma_tile_y, dma_buf, cmp_start,
                cmp_tile_x, cmp_tile_y, cmp_buf, st_start, st_tile_x, st_tile_y, st_buf};
        vec++;
        if (outs !== '0) begin
            errs++;
            $display("FAIL idle_outputs: got %h, expected 0", outs);
        end
        arm_frame();
        pulse_start();
        vec++;
        if ({dma_start, busy, dma_tile_x, dma_tile_y, dma_buf} !== 7'b11_00_00_0) begin
            errs++;
            $display("FAIL first_launch: start=%0b busy=%0b x=%0d y=%0d buf=%0d, expected 1 1 0 0 0",
                     dma_start, busy, dma_tile_x, dma_tile_y, dma_buf);
        end
    endtask

    task automatic test_full_frame();
        bit ok;
        auto_resp = 1'b0;
        do_reset();
        dma_lat = 256; cmp_lat = 196; st_lat = 1;
        auto_resp = 1'b1;
        arm_frame();
        pulse_start();
        wait_count(4, 1, 6000, ok);
        vec++;
        if (!ok) begin
            errs++;
            $display("FAIL full_timeout: frame_done count %0d, expected 1", n_fd);
        end
        vec++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL full_busy: busy=%0b at frame_done, expected 0", busy);
        end
        vec++;
        if (fd_cyc != st_done_cyc[NT-1] + 1) begin
            errs++;
            $display("FAIL full_fd_time: frame_done cycle %0d, expected %0d", fd_cyc, st_done_cyc[NT-1] + 1);
        end
        vec++;
        if (dma_start_cyc[1] != dma_done_cyc[0] + 2) begin
            errs++;
            $display("FAIL full_dma1_time: tile1 dma_start cycle %0d, expected %0d", dma_start_cyc[1],
                     dma_done_cyc[0] + 2);
        end
        repeat (5) step();
        vec++;
        if (n_fd != 1 || proto_err !== 1'b0) begin
            errs++;
            $display("FAIL full_fd_once: frame_done pulses=%0d proto_err=%0b, expected 1 and 0", n_fd, proto_err);
        end
        check_frame_counts("full");
    endtask

    task automatic test_store_stall();
        bit ok;
        auto_resp = 1'b0;
        do_reset();
        dma_lat = 10; cmp_lat = 10; st_lat = 1000;
        auto_resp = 1'b1;
        arm_frame();
        pulse_start();
        wait_count(4, 1, 20000, ok);
        vec++;
        if (!ok) begin
            errs++;
            $display("FAIL stall_timeout: frame_done count %0d, expected 1", n_fd);
        end
        vec++;
        if (dma_start_cyc[2] != st_done_cyc[0] + 2) begin
            errs++;
            $display("FAIL stall_tile2: dma_start cycle %0d, expected %0d", dma_start_cyc[2], st_done_cyc[0] + 2);
        end
        for (int k = 0; k + 2 < NT; k++) begin
            vec++;
            if (dma_start_cyc[k+2] < st_done_cyc[k] + 2) begin
                errs++;
                $display("FAIL stall_reuse: tile %0d dma_start cycle %0d, expected >= %0d", k + 2,
                         dma_start_cyc[k+2], st_done_cyc[k] + 2);
            end
        end
        check_frame_counts("stall");
    endtask

    task automatic test_simul_done();
        bit ok;
        auto_resp = 1'b0;
        do_reset();
        arm_frame();
        pulse_start();
        step();
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        wait_count(1, 1, 20, ok);
        vec++;
        if (!ok || n_dma != 2 || cmp_start_cyc[0] != dma_start_cyc[1]) begin
            errs++;
            $display("FAIL simul_setup: cmp starts=%0d dma starts=%0d, expected 1 and 2 together", n_cmp, n_dma);
        end
        step();
        dma_done = 1'b1;
        cmp_done = 1'b1;
        step();
        dma_done = 1'b0;
        cmp_done = 1'b0;
        vec++;
        if ({cmp_start, st_start} !== 2'b00) begin
            errs++;
            $display("FAIL simul_early: cmp_start=%0b st_start=%0b one cycle after dones, expected 0 0",
                     cmp_start, st_start);
        end
        step();
        vec++;
        if ({cmp_start, cmp_tile_x, cmp_tile_y, cmp_buf} !== 6'b1_01_00_1) begin
            errs++;
            $display("FAIL simul_cmp: start=%0b x=%0d y=%0d buf=%0d, expected 1 1 0 1",
                     cmp_start, cmp_tile_x, cmp_tile_y, cmp_buf);
        end
        vec++;
        if ({st_start, st_tile_x, st_tile_y, st_buf} !== 6'b1_00_00_0) begin
            errs++;
            $display("FAIL simul_st: start=%0b x=%0d y=%0d buf=%0d, expected 1 0 0 0",
                     st_start, st_tile_x, st_tile_y, st_buf);
        end
    endtask

    task automatic test_proto_and_midreset();
        bit ok;
        logic [20:0] outs;
        auto_resp = 1'b0;
        do_reset();
        dma_lat = 4; cmp_lat = 4; st_lat = 1;
        auto_resp = 1'b1;
        arm_frame();
        pulse_start();
        vec++;
        if (proto_err !== 1'b0) begin
            errs++;
            $display("FAIL perr_initial: proto_err=%0b, expected 0", proto_err);
        end
        cmp_done = 1'b1;
        step();
        cmp_done = 1'b0;
        vec++;
        if ({proto_err, cmp_start} !== 2'b10) begin
            errs++;
            $display("FAIL perr_set: proto_err=%0b cmp_start=%0b, expected 1 0", proto_err, cmp_start);
        end
        step();
        vec++;
        if (cmp_start !== 1'b0) begin
            errs++;
            $display("FAIL perr_nostart: cmp_start=%0b, expected 0", cmp_start);
        end
        wait_count(0, 6, 300, ok);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_count(4, 1, 2000, ok);
        vec++;
        if (!ok || proto_err !== 1'b1) begin
            errs++;
            $display("FAIL perr_sticky: frame_done=%0d proto_err=%0b, expected 1 1", n_fd, proto_err);
        end
        check_frame_counts("perr");
        arm_frame();
        pulse_start();
        vec++;
        if ({proto_err, dma_start} !== 2'b01) begin
            errs++;
            $display("FAIL perr_clear: proto_err=%0b dma_start=%0b, expected 0 1", proto_err, dma_start);
        end
        wait_count(3, 6, 500, ok);
        vec++;
        if (!ok || busy !== 1'b1) begin
            errs++;
            $display("FAIL mid_setup: stores=%0d busy=%0b, expected 6 1", n_std, busy);
        end
        auto_resp = 1'b0;
        dma_done = 1'b0;
        cmp_done = 1'b0;
        st_done = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        outs = {busy, frame_done, proto_err, dma_start, dma_tile_x, dma_tile_y, dma_buf, cmp_start,
                cmp_tile_x, cmp_tile_y, cmp_buf, st_start, st_tile_x, st_tile_y, st_buf};
        vec++;
        if (outs !== '0) begin
            errs++;
            $display("FAIL mid_async_reset: outputs %h, expected 0", outs);
        end
        step();
        step();
        rst = 1'b0;
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        vec++;
        if ({proto_err, dma_start, busy} !== 3'b100) begin
            errs++;
            $display("FAIL late_done: proto_err=%0b dma_start=%0b busy=%0b, expected 1 0 0",
                     proto_err, dma_start, busy);
        end
        auto_resp = 1'b1;
        arm_frame();
        pulse_start();
        vec++;
        if ({dma_start, dma_tile_x, dma_tile_y, dma_buf, proto_err} !== 7'b1_00_00_0_0) begin
            errs++;
            $display("FAIL restart: start=%0b x=%0d y=%0d buf=%0d perr=%0b, expected 1 0 0 0 0",
                     dma_start, dma_tile_x, dma_tile_y, dma_buf, proto_err);
        end
        auto_resp = 1'b0;
        do_reset();
    endtask

    task automatic test_single_tile();
        int nd, nc, ns, dk, ck, sk, fk;
        logic fbusy;
        logic coords;
        nd = 0; nc = 0; ns = 0; dk = -10; ck = -10; sk = -10; fk = -10;
        fbusy = 1'b1;
        coords = 1'b0;
        step();
        s_start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            s_start = 1'b0;
            s_dma_done = 1'b0;
            s_cmp_done = 1'b0;
            s_st_done = 1'b0;
            if (s_dma_start) begin nd++; dk = k; coords = coords | s_dma_x | s_dma_y | s_dma_buf; end
            if (s_cmp_start) begin nc++; ck = k; coords = coords | s_cmp_x | s_cmp_y | s_cmp_buf; end
            if (s_st_start) begin ns++; sk = k; coords = coords | s_st_x | s_st_y | s_st_buf; end
            if (s_frame_done) begin fk = k; fbusy = s_busy; end
            if (k == dk + 1) s_dma_done = 1'b1;
            if (k == ck + 1) s_cmp_done = 1'b1;
            if (k == sk + 1) s_st_done = 1'b1;
        end
        vec++;
        if (nd != 1 || nc != 1 || ns != 1) begin
            errs++;
            $display("FAIL single_counts: dma=%0d cmp=%0d st=%0d, expected 1 each", nd, nc, ns);
        end
        vec++;
        if (dk != 1 || ck != 4 || sk != 7) begin
            errs++;
            $display("FAIL single_timing: starts at %0d %0d %0d, expected 1 4 7", dk, ck, sk);
        end
        vec++;
        if (fk != 9 || fbusy !== 1'b0 || coords !== 1'b0 || s_proto_err !== 1'b0) begin
            errs++;
            $display("FAIL single_done: fd at %0d busy=%0b coords=%0b perr=%0b, expected 9 0 0 0",
                     fk, fbusy, coords, s_proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_store_stall();
        test_simul_done();
        test_proto_and_midreset();
        test_single_tile();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
